// File: rtl/alu_issue_queue_pkg.sv
// Shared widths, operator codes and slot record for the ALU issue queue.
package alu_issue_queue_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int ROB_W  = 4;
   localparam int OP_W   = 6;

   localparam logic [DATA_W-1:0] ZERO_DATA = '0;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

   localparam logic [OP_W-1:0] OP_ADD = 6'd1;
   localparam logic [OP_W-1:0] OP_SUB = 6'd2;
   localparam logic [OP_W-1:0] OP_AND = 6'd3;
   localparam logic [OP_W-1:0] OP_OR  = 6'd4;
   localparam logic [OP_W-1:0] OP_XOR = 6'd5;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic [ROB_W-1:0]  tag;
      logic              waiting;
   } opnd_t;

   typedef struct packed {
      logic              busy;
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] imm;
      logic [ROB_W-1:0]  reorder;
      opnd_t             rs;
      opnd_t             rt;
   } slot_t;

   // ALU port takes precedence when both CDB ports carry the awaited tag.
   function automatic opnd_t snoop(input opnd_t o,
                                   input logic a_en, input logic [ROB_W-1:0] a_tag,
                                   input logic [DATA_W-1:0] a_res,
                                   input logic l_en, input logic [ROB_W-1:0] l_tag,
                                   input logic [DATA_W-1:0] l_res);
      opnd_t r;
      r = o;
      if (o.waiting && a_en && o.tag == a_tag) begin
         r.value   = a_res;
         r.waiting = 1'b0;
      end else if (o.waiting && l_en && o.tag == l_tag) begin
         r.value   = l_res;
         r.waiting = 1'b0;
      end
      return r;
   endfunction
endpackage

// File: rtl/alu_issue_queue_if.sv
// Decoder/CDB/ALU-facing bundle of the ALU issue queue.
interface alu_issue_queue_if;
   import alu_issue_queue_pkg::*;

   logic              rdy_in;
   logic              in_rollback;
   logic              in_dispatch_enable;
   logic [OP_W-1:0]   in_dispatch_type;
   logic [ADDR_W-1:0] in_dispatch_pc;
   logic [DATA_W-1:0] in_dispatch_imm;
   logic [ROB_W-1:0]  in_dispatch_reorder;
   logic [DATA_W-1:0] in_dispatch_rs_value;
   logic [ROB_W-1:0]  in_dispatch_rs_tag;
   logic              in_dispatch_rs_busy;
   logic [DATA_W-1:0] in_dispatch_rt_value;
   logic [ROB_W-1:0]  in_dispatch_rt_tag;
   logic              in_dispatch_rt_busy;
   logic              in_cdb_alu_enable;
   logic [ROB_W-1:0]  in_cdb_alu_reorder;
   logic [DATA_W-1:0] in_cdb_alu_result;
   logic              in_cdb_lsb_enable;
   logic [ROB_W-1:0]  in_cdb_lsb_reorder;
   logic [DATA_W-1:0] in_cdb_lsb_result;
   logic              out_full;
   logic              out_alu_enable;
   logic [OP_W-1:0]   out_alu_type;
   logic [ADDR_W-1:0] out_alu_pc;
   logic [DATA_W-1:0] out_alu_imm;
   logic [DATA_W-1:0] out_alu_rs;
   logic [DATA_W-1:0] out_alu_rt;
   logic [ROB_W-1:0]  out_alu_reorder;

   modport master (
      output rdy_in, in_rollback, in_dispatch_enable, in_dispatch_type, in_dispatch_pc,
             in_dispatch_imm, in_dispatch_reorder, in_dispatch_rs_value, in_dispatch_rs_tag,
             in_dispatch_rs_busy, in_dispatch_rt_value, in_dispatch_rt_tag, in_dispatch_rt_busy,
             in_cdb_alu_enable, in_cdb_alu_reorder, in_cdb_alu_result,
             in_cdb_lsb_enable, in_cdb_lsb_reorder, in_cdb_lsb_result,
      input  out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
             out_alu_rs, out_alu_rt, out_alu_reorder
   );

   modport slave (
      input  rdy_in, in_rollback, in_dispatch_enable, in_dispatch_type, in_dispatch_pc,
             in_dispatch_imm, in_dispatch_reorder, in_dispatch_rs_value, in_dispatch_rs_tag,
             in_dispatch_rs_busy, in_dispatch_rt_value, in_dispatch_rt_tag, in_dispatch_rt_busy,
             in_cdb_alu_enable, in_cdb_alu_reorder, in_cdb_alu_result,
             in_cdb_lsb_enable, in_cdb_lsb_reorder, in_cdb_lsb_result,
      output out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
             out_alu_rs, out_alu_rt, out_alu_reorder
   );
endinterface

// File: rtl/alu_issue_queue_select.sv
// alu_issue_select: picks one ready slot. ALU_ISSUE_AGE_ORDER_EN selects oldest
// via age matrix (age[j][i]=1: j older than i); otherwise lowest index.
module alu_issue_select #(
   parameter int ENTRIES = 8
) (
   input  logic [ENTRIES-1:0]              ready,
`ifdef ALU_ISSUE_AGE_ORDER_EN
   input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
`endif
   output logic [ENTRIES-1:0]              grant,
   output logic                            valid
);
`ifdef ALU_ISSUE_AGE_ORDER_EN
   logic blocked;

   always_comb begin
      grant   = '0;
      blocked = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < ENTRIES; j++)
            if (ready[j] && age[j][i]) blocked = 1'b1;
         grant[i] = ready[i] & ~blocked;
      end
   end
`else
   assign grant = ready & (~ready + ENTRIES'(1));
`endif

   assign valid = |grant;
endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: dispatch, CDB wakeup, single issue per cycle.
// Macro ALU_ISSUE_AGE_ORDER_EN switches issue from lowest-index to oldest-first.
module alu_issue_queue
   import alu_issue_queue_pkg::*;
#(
   parameter int ENTRIES = 8
) (
   input logic          clk_in,
   input logic          rst_in,
   alu_issue_queue_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);

   slot_t              slot_q [ENTRIES];
   slot_t              new_slot;
   logic [ENTRIES-1:0] busy_vec, ready_vec, grant;
   logic               grant_vld, full;
   logic [IDX_W-1:0]   free_idx, sel_idx;
`ifdef ALU_ISSUE_AGE_ORDER_EN
   logic [ENTRIES-1:0][ENTRIES-1:0] age_q;
`endif

   // Descending scan so the lowest free index wins.
   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      free_idx  = '0;
      sel_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         busy_vec[i]  = slot_q[i].busy;
         ready_vec[i] = slot_q[i].busy & ~slot_q[i].rs.waiting & ~slot_q[i].rt.waiting;
         if (!slot_q[i].busy) free_idx = IDX_W'(i);
         if (grant[i])        sel_idx  = IDX_W'(i);
      end
   end

   assign full         = &busy_vec;
   assign bus.out_full = full;

   always_comb begin
      new_slot         = '0;
      new_slot.busy    = 1'b1;
      new_slot.op      = bus.in_dispatch_type;
      new_slot.pc      = bus.in_dispatch_pc;
      new_slot.imm     = bus.in_dispatch_imm;
      new_slot.reorder = bus.in_dispatch_reorder;
      new_slot.rs = snoop('{bus.in_dispatch_rs_value, bus.in_dispatch_rs_tag, bus.in_dispatch_rs_busy},
                          bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                          bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
      new_slot.rt = snoop('{bus.in_dispatch_rt_value, bus.in_dispatch_rt_tag, bus.in_dispatch_rt_busy},
                          bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder, bus.in_cdb_alu_result,
                          bus.in_cdb_lsb_enable, bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
   end

   alu_issue_select #(.ENTRIES(ENTRIES)) u_sel (
      .ready (ready_vec),
`ifdef ALU_ISSUE_AGE_ORDER_EN
      .age   (age_q),
`endif
      .grant (grant),
      .valid (grant_vld)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < ENTRIES; i++) begin
            slot_q[i].busy       <= 1'b0;
            slot_q[i].rs.waiting <= 1'b0;
            slot_q[i].rt.waiting <= 1'b0;
         end
         bus.out_alu_enable  <= 1'b0;
         bus.out_alu_type    <= '0;
         bus.out_alu_pc      <= ZERO_ADDR;
         bus.out_alu_imm     <= ZERO_DATA;
         bus.out_alu_rs      <= ZERO_DATA;
         bus.out_alu_rt      <= ZERO_DATA;
         bus.out_alu_reorder <= '0;
      end else if (bus.in_rollback) begin
         for (int i = 0; i < ENTRIES; i++) slot_q[i].busy <= 1'b0;
         bus.out_alu_enable <= 1'b0;
      end else if (!bus.rdy_in) begin
         bus.out_alu_enable <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (slot_q[i].busy) begin
               slot_q[i].rs <= snoop(slot_q[i].rs, bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder,
                                     bus.in_cdb_alu_result, bus.in_cdb_lsb_enable,
                                     bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
               slot_q[i].rt <= snoop(slot_q[i].rt, bus.in_cdb_alu_enable, bus.in_cdb_alu_reorder,
                                     bus.in_cdb_alu_result, bus.in_cdb_lsb_enable,
                                     bus.in_cdb_lsb_reorder, bus.in_cdb_lsb_result);
            end
            if (grant[i]) slot_q[i].busy <= 1'b0;
         end
         // free_idx is never a granted slot, so this write cannot collide with issue.
         if (bus.in_dispatch_enable && !full) slot_q[free_idx] <= new_slot;
         bus.out_alu_enable <= grant_vld;
         if (grant_vld) begin
            bus.out_alu_type    <= slot_q[sel_idx].op;
            bus.out_alu_pc      <= slot_q[sel_idx].pc;
            bus.out_alu_imm     <= slot_q[sel_idx].imm;
            bus.out_alu_rs      <= slot_q[sel_idx].rs.value;
            bus.out_alu_rt      <= slot_q[sel_idx].rt.value;
            bus.out_alu_reorder <= slot_q[sel_idx].reorder;
         end
      end
   end

`ifdef ALU_ISSUE_AGE_ORDER_EN
   // A new entry is younger than every slot busy at its dispatch edge.
   always_ff @(posedge clk_in) begin
      if (rst_in || bus.in_rollback) begin
         age_q <= '0;
      end else if (bus.rdy_in && bus.in_dispatch_enable && !full) begin
         for (int j = 0; j < ENTRIES; j++) begin
            age_q[free_idx][j] <= 1'b0;
            age_q[j][free_idx] <= busy_vec[j];
         end
      end
   end
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized + directed bench for alu_issue_queue against a sequence-number queue model.
module tb_alu_issue_queue;
   import alu_issue_queue_pkg::*;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   alu_issue_queue_if bus ();
   alu_issue_queue #(.ENTRIES(N)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

   // reference model: slots with dispatch sequence numbers
   logic        m_busy [N];
   logic [5:0]  m_op   [N];
   logic [31:0] m_pc   [N];
   logic [31:0] m_imm  [N];
   logic [3:0]  m_rob  [N];
   logic [31:0] m_v    [N][2];
   logic [3:0]  m_t    [N][2];
   logic        m_w    [N][2];
   int          m_seq  [N];
   int          seq_ctr = 0;
   logic        e_en = 1'b0;
   logic [5:0]  e_op = '0;
   logic [31:0] e_pc = '0, e_imm = '0, e_rs = '0, e_rt = '0;
   logic [3:0]  e_rob = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // {waiting, value} after snooping both CDB ports
   function automatic logic [32:0] resolve(input logic w, input logic [3:0] t, input logic [31:0] v);
      if (w && bus.in_cdb_alu_enable && t == bus.in_cdb_alu_reorder) return {1'b0, bus.in_cdb_alu_result};
      if (w && bus.in_cdb_lsb_enable && t == bus.in_cdb_lsb_reorder) return {1'b0, bus.in_cdb_lsb_result};
      return {w, v};
   endfunction

   function automatic logic model_full();
      logic f = 1'b1;
      for (int i = 0; i < N; i++) if (!m_busy[i]) f = 1'b0;
      return f;
   endfunction

   task automatic model_step();
      int pick, fr;
      logic full;
      if (rst) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
         e_en = 0; e_op = '0; e_pc = '0; e_imm = '0; e_rs = '0; e_rt = '0; e_rob = '0;
         seq_ctr = 0;
      end else if (bus.in_rollback) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
         e_en = 0;
      end else if (!bus.rdy_in) begin
         e_en = 0;
      end else begin
         full = model_full();
         fr = -1;
         pick = -1;
         for (int i = 0; i < N; i++) begin
            if (!m_busy[i] && fr < 0) fr = i;
            if (m_busy[i] && !m_w[i][0] && !m_w[i][1]) begin
`ifdef ALU_ISSUE_AGE_ORDER_EN
               if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
               if (pick < 0) pick = i;
`endif
            end
         end
         e_en = (pick >= 0);
         if (pick >= 0) begin
            e_op = m_op[pick]; e_pc = m_pc[pick]; e_imm = m_imm[pick];
            e_rs = m_v[pick][0]; e_rt = m_v[pick][1]; e_rob = m_rob[pick];
            m_busy[pick] = 1'b0;
         end
         for (int i = 0; i < N; i++)
            if (m_busy[i])
               for (int k = 0; k < 2; k++) {m_w[i][k], m_v[i][k]} = resolve(m_w[i][k], m_t[i][k], m_v[i][k]);
         if (bus.in_dispatch_enable && !full) begin
            m_busy[fr] = 1'b1;
            m_op[fr] = bus.in_dispatch_type; m_pc[fr] = bus.in_dispatch_pc;
            m_imm[fr] = bus.in_dispatch_imm; m_rob[fr] = bus.in_dispatch_reorder;
            m_t[fr][0] = bus.in_dispatch_rs_tag; m_t[fr][1] = bus.in_dispatch_rt_tag;
            {m_w[fr][0], m_v[fr][0]} = resolve(bus.in_dispatch_rs_busy, bus.in_dispatch_rs_tag, bus.in_dispatch_rs_value);
            {m_w[fr][1], m_v[fr][1]} = resolve(bus.in_dispatch_rt_busy, bus.in_dispatch_rt_tag, bus.in_dispatch_rt_value);
            m_seq[fr] = seq_ctr++;
         end
      end
   endtask

   task automatic do_edge();
      model_step();
      @(posedge clk);
      #1;
      chk("en",  32'(bus.out_alu_enable),  32'(e_en));
      chk("op",  32'(bus.out_alu_type),    32'(e_op));
      chk("pc",  bus.out_alu_pc,           e_pc);
      chk("imm", bus.out_alu_imm,          e_imm);
      chk("rs",  bus.out_alu_rs,           e_rs);
      chk("rt",  bus.out_alu_rt,           e_rt);
      chk("rob", 32'(bus.out_alu_reorder), 32'(e_rob));
   endtask

   task automatic cycle();
      chk("full", 32'(bus.out_full), 32'(model_full()));
      do_edge();
   endtask

   task automatic idle();
      rst = 1'b0;
      bus.rdy_in = 1'b1; bus.in_rollback = 1'b0; bus.in_dispatch_enable = 1'b0;
      bus.in_dispatch_type = '0; bus.in_dispatch_pc = '0; bus.in_dispatch_imm = '0;
      bus.in_dispatch_reorder = '0;
      bus.in_dispatch_rs_value = '0; bus.in_dispatch_rs_tag = '0; bus.in_dispatch_rs_busy = 1'b0;
      bus.in_dispatch_rt_value = '0; bus.in_dispatch_rt_tag = '0; bus.in_dispatch_rt_busy = 1'b0;
      bus.in_cdb_alu_enable = 1'b0; bus.in_cdb_alu_reorder = '0; bus.in_cdb_alu_result = '0;
      bus.in_cdb_lsb_enable = 1'b0; bus.in_cdb_lsb_reorder = '0; bus.in_cdb_lsb_result = '0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] rsv, input logic rsb, input logic [3:0] rst_tag,
                       input logic [31:0] rtv, input logic rtb, input logic [3:0] rtt, input logic [3:0] rob);
      bus.in_dispatch_enable = 1'b1; bus.in_dispatch_type = op;
      bus.in_dispatch_pc = 32'h1000 + 32'(rob) * 4; bus.in_dispatch_imm = 32'(rob) + 32'h40;
      bus.in_dispatch_reorder = rob;
      bus.in_dispatch_rs_value = rsv; bus.in_dispatch_rs_busy = rsb; bus.in_dispatch_rs_tag = rst_tag;
      bus.in_dispatch_rt_value = rtv; bus.in_dispatch_rt_busy = rtb; bus.in_dispatch_rt_tag = rtt;
   endtask

   task automatic cdb_alu(input logic [3:0] tag, input logic [31:0] res);
      bus.in_cdb_alu_enable = 1'b1; bus.in_cdb_alu_reorder = tag; bus.in_cdb_alu_result = res;
   endtask

   task automatic rand_inputs();
      idle();
      rst = ($urandom_range(0, 199) == 0);
      bus.in_rollback = ($urandom_range(0, 59) == 0);
      bus.rdy_in = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1)
         disp(6'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
              $urandom, 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
      bus.in_dispatch_pc = $urandom;
      bus.in_cdb_alu_enable = ($urandom_range(0, 2) == 0);
      bus.in_cdb_alu_reorder = 4'($urandom_range(0, 3));
      bus.in_cdb_alu_result = $urandom;
      bus.in_cdb_lsb_enable = ($urandom_range(0, 2) == 0);
      bus.in_cdb_lsb_reorder = 4'($urandom_range(0, 3));
      bus.in_cdb_lsb_result = $urandom;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0; m_seq[i] = 0;
         for (int k = 0; k < 2; k++) begin m_w[i][k] = 1'b0; m_v[i][k] = '0; m_t[i][k] = '0; end
      end
      idle();
      rst = 1'b1;
      do_edge();
      chk("rst_en", 32'(bus.out_alu_enable), 32'd0);
      chk("rst_full", 32'(bus.out_full), 32'd0);

      // ready ADD: issue visible two edges after dispatch, for one cycle
      idle(); disp(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3); cycle();
      chk("add_early", 32'(bus.out_alu_enable), 32'd0);
      idle(); cycle();
      chk("add_en", 32'(bus.out_alu_enable), 32'd1);
      chk("add_op", 32'(bus.out_alu_type), 32'(OP_ADD));
      chk("add_rs", bus.out_alu_rs, 32'd5);
      chk("add_rt", bus.out_alu_rt, 32'd7);
      chk("add_rob", 32'(bus.out_alu_reorder), 32'd3);
      cycle();
      chk("add_once", 32'(bus.out_alu_enable), 32'd0);

      // SUB waiting on tag 2, woken three cycles later
      disp(OP_SUB, 32'd0, 1'b1, 4'd2, 32'd9, 1'b0, 4'd0, 4'd4); cycle();
      idle(); cycle(); cycle();
      cdb_alu(4'd2, 32'h10); cycle();
      chk("sub_wait", 32'(bus.out_alu_enable), 32'd0);
      idle(); cycle();
      chk("sub_en", 32'(bus.out_alu_enable), 32'd1);
      chk("sub_rs", bus.out_alu_rs, 32'h10);

      // dispatch-cycle forwarding from the LSB port
      disp(OP_OR, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd5);
      bus.in_cdb_lsb_enable = 1'b1; bus.in_cdb_lsb_reorder = 4'd6; bus.in_cdb_lsb_result = 32'hAB;
      cycle();
      idle(); cycle();
      chk("fwd_en", 32'(bus.out_alu_enable), 32'd1);
      chk("fwd_rt", bus.out_alu_rt, 32'hAB);

      // fill all slots, overflow dispatch, wake slot 5
      for (int i = 0; i < N; i++) begin
         idle(); disp(OP_AND, 32'd0, 1'b1, 4'(8 + i), 32'd1, 1'b0, 4'd0, 4'(i)); cycle();
      end
      chk("full_set", 32'(bus.out_full), 32'd1);
      idle(); disp(OP_XOR, 32'd3, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd15); cycle();
      idle(); cdb_alu(4'd13, 32'h55); cycle();
      idle(); cycle();
      chk("wake5_rob", 32'(bus.out_alu_reorder), 32'd5);
      chk("wake5_full", 32'(bus.out_full), 32'd0);

      // rollback with concurrent dispatch and CDB
      idle(); bus.in_rollback = 1'b1;
      disp(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd9); cdb_alu(4'd8, 32'h99);
      cycle();
      chk("rb_full", 32'(bus.out_full), 32'd0);
      chk("rb_en", 32'(bus.out_alu_enable), 32'd0);
      idle();
      for (int i = 0; i < 4; i++) cycle();

      // A waiting in slot 0, B ready in slot 1, A woken as B dispatches
      disp(OP_ADD, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd1); cycle();
      idle(); disp(OP_SUB, 32'd4, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 4'd2); cdb_alu(4'd2, 32'h77); cycle();
      idle(); cycle();
      chk("order_first", 32'(bus.out_alu_reorder), 32'd1);
      cycle();
      chk("order_second", 32'(bus.out_alu_reorder), 32'd2);

      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
